// File: rtl/grad_update_seq.sv
// grad_update_seq: streams parameter/gradient reads into a gradient-descent unit and writes results back
module grad_update_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] num_params_in,
  input  logic [ADDR_W-1:0] param_base_in,
  input  logic              mode_in,
  input  logic [DATA_W-1:0] lr_in,
  output logic              param_rd_en_out,
  output logic [ADDR_W-1:0] param_rd_addr_out,
  input  logic [DATA_W-1:0] param_rd_data_in,
  output logic              grad_rd_en_out,
  output logic [ADDR_W-1:0] grad_rd_addr_out,
  input  logic [DATA_W-1:0] grad_rd_data_in,
  output logic [DATA_W-1:0] lr_out,
  output logic [DATA_W-1:0] value_old_out,
  output logic [DATA_W-1:0] grad_out,
  output logic              grad_descent_valid_out,
  output logic              grad_bias_or_weight_out,
  input  logic [DATA_W-1:0] value_updated_in,
  input  logic              grad_descent_done_in,
  output logic              param_wr_en_out,
  output logic [ADDR_W-1:0] param_wr_addr_out,
  output logic [DATA_W-1:0] param_wr_data_out,
  output logic              busy_out,
  output logic              done_out
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] n, base, cnt, a1, a2;
  logic [DATA_W-1:0] lr, held;
  logic mode, v1, v2, f1, l1, l2, l3, issue, last;
  always_comb begin
    issue = state == RUN && n != '0;
    last = cnt == n - ADDR_W'(1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_in ? RUN : IDLE;
      RUN:     state_nx = !issue ? FIN : last ? DRAIN : RUN;
      DRAIN:   state_nx = l3 ? FIN : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  assign param_rd_en_out = issue && (mode || cnt == '0);
  assign param_rd_addr_out = base + cnt;
  assign grad_rd_en_out = issue;
  assign grad_rd_addr_out = cnt;
  assign grad_descent_valid_out = v1;
  assign grad_out = v1 ? grad_rd_data_in : '0;
  // bias mode keeps feeding the first parameter read for every gradient
  assign value_old_out = !v1 ? '0 : (mode || f1) ? param_rd_data_in : held;
  assign lr_out = lr;
  assign grad_bias_or_weight_out = mode;
  assign busy_out = state == RUN || state == DRAIN || (state == FIN && n != '0);
  assign done_out = state == FIN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n <= '0;
      base <= '0;
      mode <= 1'b0;
      lr <= '0;
      cnt <= '0;
      held <= '0;
      {v1, f1, l1, v2, l2, l3} <= '0;
      a1 <= '0;
      a2 <= '0;
      param_wr_en_out <= 1'b0;
      param_wr_addr_out <= '0;
      param_wr_data_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start_in) begin
        n <= num_params_in;
        base <= param_base_in;
        mode <= mode_in;
        lr <= lr_in;
        cnt <= '0;
      end else if (issue && !last) cnt <= cnt + ADDR_W'(1);
      v1 <= issue;
      f1 <= issue && cnt == '0;
      l1 <= issue && last;
      a1 <= mode ? base + cnt : base;
      v2 <= v1;
      l2 <= l1;
      a2 <= a1;
      l3 <= l2;
      if (v1 && f1) held <= param_rd_data_in;
      // a missing done in its slot simply drops that write; the pipeline keeps moving
      param_wr_en_out <= v2 && grad_descent_done_in && (mode || l2);
      if (v2 && grad_descent_done_in && (mode || l2)) begin
        param_wr_addr_out <= a2;
        param_wr_data_out <= value_updated_in;
      end
    end
  end
endmodule

// File: tb/tb_grad_update_seq.sv
// tb_grad_update_seq: memories plus a gradient-descent model around grad_update_seq, scoreboarded writes
module tb_grad_update_seq;
  logic clk = 1'b0, rst = 1'b1, start_in = 1'b0, mode_in = 1'b0;
  logic [7:0] num_params_in = '0, param_base_in = '0;
  logic [15:0] lr_in = '0;
  logic param_rd_en_out, grad_rd_en_out, grad_descent_valid_out, grad_bias_or_weight_out;
  logic param_wr_en_out, busy_out, done_out, gd_done = 1'b0;
  logic [7:0] param_rd_addr_out, grad_rd_addr_out, param_wr_addr_out;
  logic [15:0] prd = '0, grd = '0, lr_out, value_old_out, grad_out, gd_upd = '0, param_wr_data_out;
  logic [15:0] pmem [256];
  logic [15:0] gmem [256];
  logic [31:0] acc = '0;
  logic clr = 1'b0;
  int vidx = 0, drop_idx = -1;
  int n_chk = 0, n_fail = 0;
  int prd_cnt, grd_cnt, vcnt, vfirst, vlast, bcnt, blast, dcnt, wcnt, exp_done;
  logic [63:0] sb [$];

  grad_update_seq dut (
    .clk(clk), .rst(rst), .start_in(start_in), .num_params_in(num_params_in),
    .param_base_in(param_base_in), .mode_in(mode_in), .lr_in(lr_in),
    .param_rd_en_out(param_rd_en_out), .param_rd_addr_out(param_rd_addr_out), .param_rd_data_in(prd),
    .grad_rd_en_out(grad_rd_en_out), .grad_rd_addr_out(grad_rd_addr_out), .grad_rd_data_in(grd),
    .lr_out(lr_out), .value_old_out(value_old_out), .grad_out(grad_out),
    .grad_descent_valid_out(grad_descent_valid_out), .grad_bias_or_weight_out(grad_bias_or_weight_out),
    .value_updated_in(gd_upd), .grad_descent_done_in(gd_done),
    .param_wr_en_out(param_wr_en_out), .param_wr_addr_out(param_wr_addr_out),
    .param_wr_data_out(param_wr_data_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  // one-cycle memories and a gradient-descent unit; bias mode accumulates gradients over the pass
  always @(posedge clk) begin
    if (param_rd_en_out) prd <= pmem[param_rd_addr_out];
    if (grad_rd_en_out) grd <= gmem[grad_rd_addr_out];
    if (clr) begin
      acc <= '0;
      vidx <= 0;
      gd_done <= 1'b0;
    end else begin
      gd_done <= grad_descent_valid_out && vidx != drop_idx;
      if (grad_descent_valid_out) begin
        acc <= acc + 32'(grad_out);
        gd_upd <= value_old_out - 16'((32'(lr_out) * (grad_bias_or_weight_out ? 32'(grad_out) : acc + 32'(grad_out))) >> 8);
        vidx <= vidx + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_cnt();
    {prd_cnt, grd_cnt, vcnt, bcnt, blast, dcnt, wcnt} = '0;
    vfirst = -1;
    vlast = -1;
  endtask

  task automatic sample(input int r);
    if (param_rd_en_out) prd_cnt++;
    if (grad_rd_en_out) grd_cnt++;
    if (grad_descent_valid_out) begin
      vcnt++;
      if (vfirst < 0) vfirst = r;
      vlast = r;
    end
    if (busy_out) begin
      bcnt++;
      blast = r;
    end
    if (done_out) begin
      dcnt++;
      chk("done_cyc", 64'(r), 64'(exp_done));
    end
    if (param_wr_en_out) begin
      wcnt++;
      if (sb.size() == 0) chk("wr_extra", {16'(r), param_wr_addr_out, param_wr_data_out}, 0);
      else chk("wr", {16'(r), param_wr_addr_out, param_wr_data_out}, sb.pop_front());
    end
  endtask

  task automatic run_pass(input logic [7:0] base, input logic [7:0] n, input logic mode,
                          input logic [15:0] lr, input int drop, input int extra_at);
    logic [31:0] sum;
    logic [7:0] a;
    int lim;
    sum = '0;
    clr_cnt();
    exp_done = (n == 0) ? 2 : int'(n) + 4;
    for (int i = 0; i < int'(n); i++) begin
      a = base + 8'(i);
      sum = sum + 32'(gmem[i]);
      if (mode && i != drop) sb.push_back({16'(4 + i), a, pmem[a] - 16'((32'(lr) * 32'(gmem[i])) >> 8)});
    end
    if (!mode && n != 0 && drop != int'(n) - 1)
      sb.push_back({16'(int'(n) + 3), base, pmem[base] - 16'((32'(lr) * sum) >> 8)});
    drop_idx = drop;
    clr = 1'b1;
    start_in = 1'b1;
    num_params_in = n;
    param_base_in = base;
    mode_in = mode;
    lr_in = lr;
    lim = int'(n) + 8;
    for (int r = 1; r <= lim; r++) begin
      @(negedge clk);
      clr = 1'b0;
      sample(r);
      start_in = (r == extra_at);
      num_params_in = 8'($urandom);
      param_base_in = 8'($urandom);
      mode_in = 1'($urandom);
      lr_in = 16'($urandom);
    end
    start_in = 1'b0;
    chk("done_cnt", 64'(dcnt), 1);
    chk("busy_cnt", 64'(bcnt), (n == 0) ? 1 : 64'(n) + 4);
    chk("busy_last", 64'(blast), (n == 0) ? 1 : 64'(n) + 4);
    chk("valid_cnt", 64'(vcnt), 64'(n));
    if (n != 0) chk("valid_span", {32'(vfirst), 32'(vlast)}, {32'd2, 32'(n) + 32'd1});
    chk("prd_cnt", 64'(prd_cnt), mode ? 64'(n) : 64'(n != 0));
    chk("grd_cnt", 64'(grd_cnt), 64'(n));
    chk("sb_left", 64'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 16'($urandom);
      gmem[i] = 16'($urandom_range(0, 1023));
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(|{param_rd_en_out, grad_rd_en_out, grad_descent_valid_out, param_wr_en_out,
                            busy_out, done_out, grad_bias_or_weight_out, lr_out, value_old_out, grad_out}), 0);
    rst = 1'b0;
    @(negedge clk);
    pmem[8'h10] = 16'h0100; pmem[8'h11] = 16'h0200; pmem[8'h12] = 16'h0300;
    gmem[0] = 16'h0100; gmem[1] = 16'h0100; gmem[2] = 16'h0200;
    run_pass(8'h10, 8'd3, 1'b1, 16'h0080, -1, -1);
    pmem[8'h20] = 16'h0100;
    for (int i = 0; i < 4; i++) gmem[i] = 16'h0040;
    run_pass(8'h20, 8'd4, 1'b0, 16'h0100, -1, -1);
    run_pass(8'h33, 8'd0, 1'b1, 16'h0100, -1, -1);
    for (int i = 0; i < 8; i++) gmem[i] = 16'($urandom_range(0, 1023));
    run_pass(8'hFE, 8'd3, 1'b1, 16'h0040, -1, -1);
    run_pass(8'h50, 8'd4, 1'b1, 16'h00C0, 1, -1);
    run_pass(8'h60, 8'd5, 1'b1, 16'h0020, -1, 3);
    run_pass(8'h70, 8'd6, 1'b0, 16'h0030, -1, 2);
    run_pass(8'h80, 8'd3, 1'b0, 16'h0030, 2, -1);
    // abort an N=5 weight pass with reset; nothing from it may appear afterwards
    clr_cnt();
    exp_done = -1;
    clr = 1'b1;
    start_in = 1'b1;
    num_params_in = 8'd5;
    param_base_in = 8'h40;
    mode_in = 1'b1;
    lr_in = 16'h0080;
    for (int r = 1; r <= 14; r++) begin
      @(negedge clk);
      clr = 1'b0;
      start_in = 1'b0;
      sample(r);
      if (r == 3) rst = 1'b1;
      if (r == 5) begin
        chk("rst_outs", 64'(|{param_rd_en_out, grad_rd_en_out, grad_descent_valid_out, param_wr_en_out,
                              busy_out, done_out, grad_bias_or_weight_out, lr_out, value_old_out, grad_out,
                              param_wr_addr_out, param_wr_data_out}), 0);
        rst = 1'b0;
      end
    end
    chk("rst_wr", 64'(wcnt), 0);
    chk("rst_done", 64'(dcnt), 0);
    run_pass(8'h40, 8'd5, 1'b1, 16'h0080, -1, -1);
    for (int i = 0; i < 256; i++) gmem[i] = 16'($urandom_range(0, 1023));
    run_pass(8'h9A, 8'd255, 1'b1, 16'h0011, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/grad_update_seq.md
GRAD_UPDATE_SEQ -- requirements
Module: grad_update_seq

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 8, memory address width; DATA_W, default 16, Q8.8 fixed-point data width.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start_in  input  1  one-cycle request to run an update pass; sampled only in IDLE.
REQ-005 num_params_in  input  ADDR_W  gradient count N, sampled with start_in.
REQ-006 param_base_in  input  ADDR_W  first parameter address, sampled with start_in.
REQ-007 mode_in  input  1  1 = weight mode, 0 = bias mode; sampled with start_in.
REQ-008 lr_in  input  DATA_W  learning rate, sampled with start_in.
REQ-009 param_rd_en_out / param_rd_addr_out  output  1 / ADDR_W  parameter memory read port; data is returned one cycle later.
REQ-010 param_rd_data_in  input  DATA_W  parameter read data.
REQ-011 grad_rd_en_out / grad_rd_addr_out  output  1 / ADDR_W  gradient memory read port; data is returned one cycle later.
REQ-012 grad_rd_data_in  input  DATA_W  gradient read data.
REQ-013 lr_out, value_old_out, grad_out  output  DATA_W each  operands for the gradient-descent unit.
REQ-014 grad_descent_valid_out, grad_bias_or_weight_out  output  1 each  gradient-descent unit valid and mode.
REQ-015 value_updated_in, grad_descent_done_in  input  DATA_W / 1  gradient-descent unit result; done arrives one cycle after valid.
REQ-016 param_wr_en_out / param_wr_addr_out / param_wr_data_out  output  1 / ADDR_W / DATA_W  parameter write-back port.
REQ-017 busy_out / done_out  output  1 / 1  pass in progress / one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and FIN; transitions are IDLE->RUN on start_in, RUN->DRAIN after the last read issue, DRAIN->FIN after the last write, and FIN->IDLE after one cycle.
REQ-019 When start_in is sampled in IDLE at cycle 0, reads for index i SHALL issue in cycle 1+i (i = 0..N-1).
REQ-020 grad_rd_addr_out SHALL be i.
REQ-021 In weight mode, param_rd_addr_out SHALL be (param_base+i) mod 2^ADDR_W, with param_rd_en_out set on every issue.
REQ-022 In bias mode, param_rd_en_out SHALL be asserted only for i=0, with address param_base.
REQ-023 grad_descent_valid_out SHALL be high in cycle 2+i, with grad_out = grad_rd_data_in and value_old_out = param_rd_data_in; in bias mode, value_old_out SHALL hold the i=0 value.
REQ-024 Valid SHALL be contiguous for all N indices, with no bubbles.
REQ-025 grad_bias_or_weight_out SHALL equal the sampled mode and lr_out SHALL equal the sampled lr_in, both held constant for the whole pass.
REQ-026 The write-back address SHALL be carried through an internal 3-stage pipeline matched to the read and unit latency.
REQ-027 A write SHALL occur in the cycle after grad_descent_done_in is high, with data = value_updated_in registered.
REQ-028 In weight mode, the write for index i SHALL land in cycle 4+i.
REQ-029 In bias mode, only the final result (i=N-1) SHALL be written, to param_base, in cycle N+3.
REQ-030 If grad_descent_done_in is low in an expected slot, that write SHALL be skipped and the FSM SHALL still advance.
REQ-031 done_out SHALL pulse in cycle N+4 (FIN).
REQ-032 busy_out SHALL be high from cycle 1 through cycle N+4 inclusive.
REQ-033 When N=0, start SHALL cause no reads, no valid and no writes; busy_out SHALL be high in cycle 1 only and done_out SHALL pulse in cycle 2.
REQ-034 start_in while not IDLE SHALL be ignored, with no queuing.
REQ-035 Address arithmetic SHALL wrap modulo 2^ADDR_W; an N of 2^ADDR_W-1 SHALL be fully supported.
REQ-036 No arithmetic SHALL be performed in this block; all data SHALL pass through unmodified.

Reset
REQ-037 rst SHALL force IDLE on the next rising edge and zero all outputs and internal counters and pipelines.
REQ-038 rst asserted mid-pass SHALL abort the pass with no further reads or writes, no done_out pulse, and no pending write emitted after reset.
REQ-039 The first start_in SHALL be accepted in the cycle after rst deasserts.

Verification
REQ-040 Weight pass: base 0x10, N=3, lr 0x0080, params [0x0100,0x0200,0x0300], grads [0x0100,0x0100,0x0200], with a gradient_descent model attached -> writes (0x10,0x0080)@4, (0x11,0x0180)@5, (0x12,0x0200)@6, and done_out@7.
REQ-041 Bias pass: base 0x20, N=4, lr 0x0100, param 0x0100, grads 4x0x0040 -> exactly one param read, valid high for cycles 2-5 contiguously, a single write (0x20,0x0000)@7, and done_out@8.
REQ-042 N=0 start -> no rd_en, valid or wr_en; done_out@2; busy_out high in cycle 1 only.
REQ-043 Wrap: base 0xFE, N=3, weight mode -> write addresses 0xFE, 0xFF, 0x00.
REQ-044 rst in cycle 3 of an N=5 weight pass -> no wr_en and no done_out afterward, all outputs 0, and a new start accepted cleanly.
REQ-045 start_in pulsed during busy -> ignored, and only the original pass's writes and single done_out are seen.
